down_counter: RTL and testbench

//  Loadable down-counter with terminal flag; the counting partner of the adder's
//  up-counter. It loads a start value, decrements on enable and flags arrival at

---
 rtl/down_counter.sv | 117 +++++++++++
 tb/tb_down_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
//   Loadable W-bit down-counter with an IDLE/RUN/DONE FSM. A load restarts the
//   count from any state; en decrements while running. On arrival at zero the
//   FSM parks in DONE (R=1) and emits a one-cycle done pulse.
//   All outputs are registered; reset is synchronous, active-low.
//
//   Optional feature macro: AUTO_RELOAD_EN
//     When defined, a reload register captures val on every load. Reaching the
//     end of a count in RUN reloads from it and stays in RUN, giving a periodic
//     done pulse. A load of 0 still goes to DONE.
// ---------------------------------------------------------------------------
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] val,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         R
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [W-1:0] ONE = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         done_q,  done_d;
  logic         busy_q;
  logic         r_q;

`ifdef AUTO_RELOAD_EN
  logic [W-1:0] reload_q, reload_d;
`endif

  // Next-state and next-output logic: priority is load over en.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (load) begin
`ifdef AUTO_RELOAD_EN
      reload_d = val;
`endif
      if (val == '0) begin
        state_d = S_DONE;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        count_d = val;
      end
    end else if (state_q == S_RUN && en) begin
      // RUN is only entered with a non-zero count, so "not above one" means
      // this is the final enabled cycle of the count.
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        // The reload value is non-zero here: RUN was entered by a non-zero load.
        count_d = reload_q;
`else
        state_d = S_DONE;
        count_d = '0;
`endif
      end
    end
    // IDLE and DONE ignore en; without a load they simply hold.
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      r_q      <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
      busy_q   <= (state_d == S_RUN);
      r_q      <= (state_d == S_DONE);
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign R     = r_q;

endmodule

// File: tb/tb_down_counter.sv
// ---------------------------------------------------------------------------
// tb_down_counter
//   Directed vector table, a hand-written enable-toggling sequence and a
//   randomized phase checked against a behavioural model. Follows the
//   AUTO_RELOAD_EN macro the same way the design does.
// ---------------------------------------------------------------------------
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] val;
  logic         load;
  logic         en;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         r;

  int errors = 0;
  int checks = 0;

  down_counter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (val),
    .load  (load),
    .en    (en),
    .count (count),
    .busy  (busy),
    .done  (done),
    .R     (r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         load;
    logic         en;
    logic [W-1:0] val;
    int           exp_count;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_r;
  } vec_t;

  // Behavioural model: remaining count, whether a count is in progress,
  // whether the last count finished, and the remembered start value.
  int m_remaining = 0;
  bit m_counting  = 0;
  bit m_finished  = 0;
  bit m_pulse     = 0;
  int m_period    = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_edge();
    m_pulse = 0;
    if (!rst_n) begin
      m_remaining = 0; m_counting = 0; m_finished = 0; m_period = 0;
    end else if (load) begin
      m_period    = int'(val);
      m_remaining = int'(val);
      m_counting  = (val != 0);
      m_finished  = (val == 0);
      m_pulse     = (val == 0);
    end else if (m_counting && en) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        m_pulse = 1;
`ifdef AUTO_RELOAD_EN
        m_remaining = m_period;
`else
        m_counting = 0;
        m_finished = 1;
`endif
      end
    end
  endtask

  // Apply inputs, take one clock edge, sample 1 time unit later.
  task automatic step(input logic r_n, input logic l, input logic e, input logic [W-1:0] v);
    rst_n = r_n; load = l; en = e; val = v;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, int'(count), m_remaining);
    check({tag, ".busy"},  int'(busy),  int'(m_counting));
    check({tag, ".done"},  int'(done),  int'(m_pulse));
    check({tag, ".R"},     int'(r),     int'(m_finished));
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; load = 1'b0; en = 1'b0; val = '0;

`ifndef AUTO_RELOAD_EN
    // reset, idle, count 5 to zero, hold in DONE, load-0 pulses
    vecs.push_back('{0,0,0,4'd0, 0,0,0,0});
    vecs.push_back('{0,0,0,4'd0, 0,0,0,0});
    vecs.push_back('{1,0,0,4'd0, 0,0,0,0});
    vecs.push_back('{1,0,1,4'd0, 0,0,0,0});
    vecs.push_back('{1,1,1,4'd5, 5,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 4,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 3,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 2,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 1,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 0,0,1,1});
    vecs.push_back('{1,0,1,4'd0, 0,0,0,1});
    vecs.push_back('{1,0,1,4'd0, 0,0,0,1});
    vecs.push_back('{1,1,0,4'd0, 0,0,1,1});
    vecs.push_back('{1,1,0,4'd0, 0,0,1,1});
    vecs.push_back('{1,0,0,4'd0, 0,0,0,1});
    // mid-count reload 7 -> 2, hold on !en
    vecs.push_back('{1,1,1,4'd7, 7,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 6,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 5,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 4,1,0,0});
    vecs.push_back('{1,1,1,4'd2, 2,1,0,0});
    vecs.push_back('{1,0,0,4'd0, 2,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 1,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 0,0,1,1});
    // reset abort mid-count; reset beats load
    vecs.push_back('{1,1,1,4'd6, 6,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 5,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 4,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 3,1,0,0});
    vecs.push_back('{0,0,1,4'd0, 0,0,0,0});
    vecs.push_back('{0,1,1,4'd5, 0,0,0,0});
    // full-scale load, first decrement
    vecs.push_back('{1,1,1,4'd15, 15,1,0,0});
    vecs.push_back('{1,0,1,4'd0, 14,1,0,0});
`else
    // periodic reload of 3, then load-0 to DONE
    vecs.push_back('{0,0,0,4'd0, 0,0,0,0});
    vecs.push_back('{0,0,0,4'd0, 0,0,0,0});
    vecs.push_back('{1,1,1,4'd3, 3,1,0,0});
    for (int i = 1; i <= 10; i++)
      vecs.push_back('{1,0,1,4'd0, 3 - ((i - 1) % 3 + 1) + ((i % 3 == 0) ? 3 : 0),
                       1, (i % 3 == 0), 0});
    vecs.push_back('{1,1,1,4'd0, 0,0,1,1});
    vecs.push_back('{1,0,1,4'd0, 0,0,0,1});
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].load, vecs[i].en, vecs[i].val);
      check($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
      check($sformatf("vec%0d.busy",  i), int'(busy),  int'(vecs[i].exp_busy));
      check($sformatf("vec%0d.done",  i), int'(done),  int'(vecs[i].exp_done));
      check($sformatf("vec%0d.R",     i), int'(r),     int'(vecs[i].exp_r));
    end

`ifndef AUTO_RELOAD_EN
    // Load 9 with en toggling: only enabled cycles decrement.
    begin
      int enabled = 0;
      step(1, 1, 1, 4'd9);
      check("tog.load", int'(count), 9);
      for (int i = 0; i < 18; i++) begin
        logic e;
        e = (i % 2 == 0);
        step(1, 0, e, 4'd0);
        if (e) enabled++;
        check($sformatf("tog%0d.count", i), int'(count), 9 - enabled);
        check($sformatf("tog%0d.R",     i), int'(r),     int'(enabled == 9));
        check($sformatf("tog%0d.done",  i), int'(done),  int'(e && enabled == 9));
      end
    end
`endif

    // Randomized phase against the model.
    step(0, 0, 0, 4'd0);
    check_model("rnd.reset");
    for (int i = 0; i < 600; i++) begin
      logic         r_n, l, e;
      logic [W-1:0] v;
      r_n = ($urandom_range(0, 59) != 0);
      l   = ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 15));
      step(r_n, l, e, v);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
